// File: rtl/avr_pkg.sv
// Types and constants shared by the AVR core and its instruction fetch path.
package avr_pkg;
    localparam int AW = 16;

    typedef logic [AW-1:0] pc_t;
    typedef logic [15:0]   insn_t;

    localparam pc_t RESET_VECTOR = '0;
endpackage

// File: rtl/avr_ifetch_fifo.sv
// Small prefetch queue of {instruction word, word address} pairs.
// A flush empties it in one edge; the head reads as zero while it is empty.
module avr_ifetch_fifo
    import avr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = avr_pkg::AW
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  insn_t                      i_pushWord,
    input  logic [AW-1:0]              i_pushPc,
    input  logic                       i_pop,
    output logic                       o_valid,
    output insn_t                      o_headWord,
    output logic [AW-1:0]              o_headPc,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    insn_t         r_word [DEPTH];
    logic [AW-1:0] r_pc   [DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset_n || i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wrPtr <= r_wrPtr + PW'(1);
            if (i_pop)  r_rdPtr <= r_rdPtr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clock) begin
        if (reset_n && !i_flush && i_push) begin
            r_word[r_wrPtr] <= i_pushWord;
            r_pc[r_wrPtr]   <= i_pushPc;
        end
    end

    assign o_valid    = (r_count != '0);
    assign o_headWord = o_valid ? r_word[r_rdPtr] : '0;
    assign o_headPc   = o_valid ? r_pc[r_rdPtr]   : '0;
    assign o_count    = r_count;
endmodule

// File: rtl/avr_ifetch.sv
// Instruction prefetch unit: issues sequential ROM reads, queues the returning
// words with their addresses, and restarts cleanly on a redirect from the core.
module avr_ifetch
    import avr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = avr_pkg::AW
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [AW-1:0] rom_addr,
    output logic          rom_rd,
    input  insn_t         rom_data,
    output logic          ir_valid,
    output insn_t         ir,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    logic [AW-1:0] r_fetchPc;
    logic [AW-1:0] r_romAddr;
    logic [AW-1:0] r_dataPc;
    logic          r_romRd;
    logic          r_inflight;

    logic [CW-1:0] w_count;
    logic [OW-1:0] w_outstanding;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;

    // Queued words plus both reads still on their way must fit in the queue,
    // so a stalled core can never cause an overflow.
    assign w_pop         = ir_valid & ir_ready;
    assign w_push        = r_inflight & ~redirect;
    assign w_outstanding = OW'(w_count) + OW'(r_inflight) + OW'(r_romRd) - OW'(w_pop);
    assign w_issue       = (w_outstanding < OW'(DEPTH));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_fetchPc  <= AW'(RESET_VECTOR);
            r_romAddr  <= '0;
            r_romRd    <= 1'b0;
            r_inflight <= 1'b0;
            r_dataPc   <= '0;
        end else if (redirect) begin
            // The read issued this cycle returns next cycle and must be dropped.
            r_romRd    <= 1'b1;
            r_romAddr  <= redirect_pc;
            r_fetchPc  <= redirect_pc + AW'(1);
            r_inflight <= 1'b0;
            r_dataPc   <= r_romAddr;
        end else begin
            r_inflight <= r_romRd;
            r_dataPc   <= r_romAddr;
            if (w_issue) begin
                r_romRd   <= 1'b1;
                r_romAddr <= r_fetchPc;
                r_fetchPc <= r_fetchPc + AW'(1);
            end else begin
                r_romRd <= 1'b0;
            end
        end
    end

    assign rom_addr = r_romAddr;
    assign rom_rd   = r_romRd;

    avr_ifetch_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_flush    (redirect),
        .i_push     (w_push),
        .i_pushWord (rom_data),
        .i_pushPc   (r_dataPc),
        .i_pop      (w_pop),
        .o_valid    (ir_valid),
        .o_headWord (ir),
        .o_headPc   (ir_pc),
        .o_count    (w_count)
    );
endmodule

// File: tb/tb_avr_ifetch.sv
// Bench for avr_ifetch: a ROM model plus a stream-level reference that tracks
// which address the core must see next and when the first word must appear.
module tb_avr_ifetch;
    import avr_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [15:0] rom_data = 16'h0000;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [15:0] expPc;
    logic [15:0] issueAddr;
    logic        lastWasReset;
    int          age;
    int          validAge;
    int          issueAge;

    avr_ifetch #(
        .DEPTH (4),
        .AW    (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rom_addr    (rom_addr),
        .rom_rd      (rom_rd),
        .rom_data    (rom_data),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] romWord(input logic [15:0] pc);
        return 16'hE000 + pc;
    endfunction

    always @(posedge clock) begin
        if (rom_rd) rom_data <= romWord(rom_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: check what the DUT shows now, then drive the inputs for the next edge
    // and advance the reference stream accordingly.
    task automatic applyStimulus(input logic rn, input logic rdr, input logic [15:0] rpc, input logic rdy);
        @(negedge clock);
        age++;
        if (ir_valid === 1'b1) begin
            checkOutput("irPc",   32'(ir_pc), 32'(expPc));
            checkOutput("irWord", 32'(ir),    32'(romWord(expPc)));
        end else begin
            checkOutput("idlePc",   32'(ir_pc), 32'd0);
            checkOutput("idleWord", 32'(ir),    32'd0);
        end
        if (age < validAge)
            checkOutput("latencyGap", 32'(ir_valid), 32'd0);
        else if (age == validAge)
            checkOutput("latencyFirst", 32'(ir_valid), 32'd1);
        if (age == issueAge) begin
            checkOutput("issueRd",   32'(rom_rd),   32'd1);
            checkOutput("issueAddr", 32'(rom_addr), 32'(issueAddr));
        end
        if (lastWasReset && age == 1) begin
            checkOutput("resetRd",   32'(rom_rd),   32'd0);
            checkOutput("resetAddr", 32'(rom_addr), 32'd0);
        end

        reset_n     = rn;
        redirect    = rdr;
        redirect_pc = rpc;
        ir_ready    = rdy;

        if (!rn) begin
            expPc        = 16'h0000;
            age          = 0;
            validAge     = 4;
            issueAge     = 2;
            issueAddr    = 16'h0000;
            lastWasReset = 1'b1;
        end else if (rdr) begin
            expPc        = rpc;
            age          = 0;
            validAge     = 3;
            issueAge     = 1;
            issueAddr    = rpc;
            lastWasReset = 1'b0;
        end else if (ir_valid === 1'b1 && rdy) begin
            expPc = expPc + 16'h0001;
        end
    endtask

    initial begin
        logic        rn;
        logic        rdr;
        logic        rdy;
        logic [15:0] rpc;

        reset_n      = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 16'h0000;
        ir_ready     = 1'b0;
        expPc        = 16'h0000;
        issueAddr    = 16'h0000;
        lastWasReset = 1'b1;
        age          = 0;
        validAge     = 4;
        issueAge     = 2;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        // Stalled core: queue saturates, issue stops, then drains in order.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("satRomRd", 32'(rom_rd),   32'd0);
        checkOutput("satValid", 32'(ir_valid), 32'd1);
        checkOutput("satHead",  32'(ir_pc),    32'd0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        // Redirect with words queued and a read in flight.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0100, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'h0010, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'h0020, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        applyStimulus(1'b1, 1'b1, 16'hFFFE, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        for (int i = 0; i < 600; i++) begin
            rn  = ($urandom_range(0, 99) != 0);
            rdr = ($urandom_range(0, 19) == 0);
            rpc = 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(rn, rdr, rpc, rdy);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
